// File: rtl/mac_host_seq.sv
// Host-side sequencer for the 8x8 MAC core: clears the accumulator, streams N operand
// pairs, reads the 16-bit result back over the split bus and reports shadow overflow.
module mac_host_seq #(
  parameter int LEN_W    = 8,
  parameter int TURN_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_ovf,
  output logic             busy,
  output logic             mac_rst_n,
  output logic             mac_acc_en,
  output logic [7:0]       mac_in_a,
  output logic [7:0]       mac_in_b,
  input  logic [7:0]       mac_out_low,
  output logic             mac_io_drive,
  input  logic [7:0]       mac_io_high_in
);

  localparam int SUM_W = 16 + LEN_W;

  // SAMPLE is never entered: the high-byte sample happens on the last TURN edge.
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, TURN, SAMPLE, RESP} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [3:0]       turn_q, turn_d;
  logic             mac_rst_n_q, mac_rst_n_d;
  logic             acc_en_q, acc_en_d;
  logic [7:0]       in_a_q, in_a_d, in_b_q, in_b_d;
  logic             drive_q, drive_d;
  logic [15:0]      res_data_q, res_data_d;
  logic             res_ovf_q, res_ovf_d;
  logic [15:0]      prod;

  assign cmd_ready    = (state_q == IDLE);
  assign op_ready     = (state_q == FEED) && (cnt_q < len_q);
  assign res_valid    = (state_q == RESP);
  assign busy         = (state_q != IDLE);
  assign res_data     = res_data_q;
  assign res_ovf      = res_ovf_q;
  assign mac_rst_n    = mac_rst_n_q;
  assign mac_acc_en   = acc_en_q;
  assign mac_in_a     = in_a_q;
  assign mac_in_b     = in_b_q;
  assign mac_io_drive = drive_q;
  assign prod         = {8'h00, op_a} * {8'h00, op_b};

  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    turn_d      = turn_q;
    mac_rst_n_d = 1'b1;
    acc_en_d    = 1'b0;
    in_a_d      = in_a_q;
    in_b_d      = in_b_q;
    drive_d     = 1'b0;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          len_d       = cmd_len;
          cnt_d       = '0;
          sum_d       = '0;
          mac_rst_n_d = 1'b0;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        turn_d = '0;
        if (len_q == '0) begin
          drive_d = 1'b1;
          state_d = TURN;
        end else begin
          state_d = FEED;
        end
      end
      FEED: begin
        if (op_valid && op_ready) begin
          in_a_d   = op_a;
          in_b_d   = op_b;
          acc_en_d = 1'b1;
          sum_d    = sum_q + {{LEN_W{1'b0}}, prod};
          cnt_d    = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        turn_d  = '0;
        drive_d = 1'b1;
        state_d = TURN;
      end
      TURN: begin
        if (turn_q == 4'(TURN_CYC - 1)) begin
          res_data_d = {mac_io_high_in, mac_out_low};
          res_ovf_d  = (sum_q[SUM_W-1:16] != '0);
          state_d    = RESP;
        end else begin
          turn_d  = turn_q + 4'd1;
          drive_d = 1'b1;
        end
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      turn_q      <= '0;
      mac_rst_n_q <= 1'b0;
      acc_en_q    <= 1'b0;
      in_a_q      <= '0;
      in_b_q      <= '0;
      drive_q     <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      turn_q      <= turn_d;
      mac_rst_n_q <= mac_rst_n_d;
      acc_en_q    <= acc_en_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      drive_q     <= drive_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_host_seq.sv
// Directed bench for mac_host_seq: behavioural MAC core per instance, expected results
// queued as operands are driven and compared when the result handshake arrives.
module tb_mac_host_seq;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             cmd_valid, cmd_ready, op_valid, op_ready, res_valid, res_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0]       op_a, op_b, mac_in_a, mac_in_b, mac_out_low, mac_io_high;
  logic [15:0]      res_data, acc;
  logic             res_ovf, busy, mac_rst_n, mac_acc_en, mac_io_drive;

  logic             b_cmd_valid, b_cmd_ready, b_op_valid, b_op_ready, b_res_valid, b_res_ready;
  logic [LEN_W-1:0] b_cmd_len;
  logic [7:0]       b_op_a, b_op_b, b_mac_in_a, b_mac_in_b, b_mac_out_low, b_mac_io_high;
  logic [15:0]      b_res_data, b_acc;
  logic             b_res_ovf, b_busy, b_mac_rst_n, b_mac_acc_en, b_mac_io_drive;

  mac_host_seq #(.LEN_W(LEN_W), .TURN_CYC(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf),
    .busy(busy), .mac_rst_n(mac_rst_n), .mac_acc_en(mac_acc_en), .mac_in_a(mac_in_a),
    .mac_in_b(mac_in_b), .mac_out_low(mac_out_low), .mac_io_drive(mac_io_drive),
    .mac_io_high_in(mac_io_high)
  );

  mac_host_seq #(.LEN_W(LEN_W), .TURN_CYC(3)) dut_t3 (
    .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_len(b_cmd_len),
    .op_valid(b_op_valid), .op_ready(b_op_ready), .op_a(b_op_a), .op_b(b_op_b),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_data(b_res_data), .res_ovf(b_res_ovf),
    .busy(b_busy), .mac_rst_n(b_mac_rst_n), .mac_acc_en(b_mac_acc_en), .mac_in_a(b_mac_in_a),
    .mac_in_b(b_mac_in_b), .mac_out_low(b_mac_out_low), .mac_io_drive(b_mac_io_drive),
    .mac_io_high_in(b_mac_io_high)
  );

  // MAC core models: async clear, 16-bit wrapping accumulator, high byte only valid when driven.
  always_ff @(posedge clk or negedge mac_rst_n)
    if (!mac_rst_n) acc <= '0;
    else if (mac_acc_en) acc <= acc + {8'h00, mac_in_a} * {8'h00, mac_in_b};
  always_ff @(posedge clk or negedge b_mac_rst_n)
    if (!b_mac_rst_n) b_acc <= '0;
    else if (b_mac_acc_en) b_acc <= b_acc + {8'h00, b_mac_in_a} * {8'h00, b_mac_in_b};
  assign mac_out_low   = acc[7:0];
  assign mac_io_high   = mac_io_drive ? acc[15:8] : 8'hA5;
  assign b_mac_out_low = b_acc[7:0];
  assign b_mac_io_high = b_mac_io_drive ? b_acc[15:8] : 8'hA5;

  int cyc = 0, acc_pulses = 0, drv_cyc = 0, res_hs = 0, b_drv_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mac_acc_en) acc_pulses <= acc_pulses + 1;
    if (mac_io_drive) drv_cyc <= drv_cyc + 1;
    if (res_valid && res_ready) res_hs <= res_hs + 1;
    if (b_mac_io_drive) b_drv_cyc <= b_drv_cyc + 1;
  end

  typedef struct packed {
    logic [15:0] data;
    logic        ovf;
  } res_t;

  res_t sb[$];
  int   checks = 0, failures = 0;
  int   exp_sum, cmd_edge;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int n);
    int guard = 0;
    while (!cmd_ready && guard < 50) begin tick(); guard++; end
    check("cmd_ready_wait", cmd_ready, 1);
    exp_sum   = 0;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(n);
    tick();
    cmd_edge  = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b);
    int guard = 0;
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    while (!op_ready && guard < 50) begin tick(); guard++; end
    check("op_ready_wait", op_ready, 1);
    tick();
    op_valid = 1'b0;
    exp_sum += int'(a) * int'(b);
    check("acc_en_pulse", mac_acc_en, 1);
    check("mac_in_a", mac_in_a, a);
    check("mac_in_b", mac_in_b, b);
  endtask

  task automatic push_exp();
    sb.push_back({exp_sum[15:0], exp_sum > 65535});
  endtask

  task automatic wait_res();
    int guard = 0;
    while (!res_valid && guard < 100) begin tick(); guard++; end
    check("res_valid_wait", res_valid, 1);
  endtask

  task automatic check_res(input string tag, input logic [15:0] data, input logic ovf);
    res_t e;
    e = sb.pop_front();
    check({tag, "_data"}, data, e.data);
    check({tag, "_ovf"}, ovf, e.ovf);
  endtask

  initial begin
    int a0, d0, h0, guard;
    rst = 1'b1;
    {cmd_valid, op_valid, res_ready, cmd_len, op_a, op_b} = '0;
    {b_cmd_valid, b_op_valid, b_res_ready, b_cmd_len, b_op_a, b_op_b} = '0;
    tick(); tick();
    check("rst_mac_rst_n", mac_rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_io_drive", mac_io_drive, 0);
    check("rst_res_data", res_data, 0);
    rst = 1'b0;
    tick();
    check("cmd_ready_after_rst", cmd_ready, 1);

    // N=1 (3,5), consumer always ready
    res_ready = 1'b1;
    a0 = acc_pulses; d0 = drv_cyc;
    send_cmd(1);
    check("clear_mac_rst_n", mac_rst_n, 0);
    check("busy_in_clear", busy, 1);
    check("cmd_ready_busy", cmd_ready, 0);
    send_op(8'd3, 8'd5);
    push_exp();
    wait_res();
    check("lat_n1", cyc - cmd_edge, 4);
    check_res("n1", res_data, res_ovf);
    tick();
    check("res_valid_pulse", res_valid, 0);
    check("drive_cyc_n1", drv_cyc - d0, 1);
    check("acc_pulses_n1", acc_pulses - a0, 1);

    // N=2 with overflow past 16 bits
    send_cmd(2);
    send_op(8'd255, 8'd255);
    check("op_during_feed_cmd_ready", cmd_ready, 0);
    send_op(8'd255, 8'd255);
    push_exp();
    wait_res();
    check("lat_n2", cyc - cmd_edge, 5);
    check_res("n2_ovf", res_data, res_ovf);
    tick();

    // N=0: no pairs, no accumulate
    a0 = acc_pulses;
    send_cmd(0);
    push_exp();
    wait_res();
    check("lat_n0", cyc - cmd_edge, 2);
    check_res("n0", res_data, res_ovf);
    check("acc_pulses_n0", acc_pulses - a0, 0);
    tick();

    // N=3 with op gaps and a stalled consumer
    res_ready = 1'b0;
    a0 = acc_pulses; h0 = res_hs;
    send_cmd(3);
    send_op(8'd1, 8'd2); tick();
    send_op(8'd3, 8'd4); tick();
    send_op(8'd5, 8'd6);
    push_exp();
    wait_res();
    for (int i = 0; i < 5; i++) tick();
    check("stall_res_valid_held", res_valid, 1);
    check_res("stall", res_data, res_ovf);
    res_ready = 1'b1;
    tick();
    check("stall_res_released", res_valid, 0);
    check("stall_single_hs", res_hs - h0, 1);
    check("acc_pulses_n3", acc_pulses - a0, 3);

    // back-to-back commands must not carry the accumulator over
    send_cmd(1);
    send_op(8'd10, 8'd10);
    push_exp();
    wait_res();
    check_res("b2b_first", res_data, res_ovf);
    tick();
    send_cmd(1);
    send_op(8'd2, 8'd3);
    push_exp();
    wait_res();
    check_res("b2b_second", res_data, res_ovf);
    tick();

    // reset mid-command after 2 of 4 pairs
    send_cmd(4);
    send_op(8'd9, 8'd9);
    send_op(8'd9, 8'd9);
    rst = 1'b1;
    #2;
    check("midrst_mac_rst_n", mac_rst_n, 0);
    check("midrst_busy", busy, 0);
    check("midrst_op_ready", op_ready, 0);
    check("midrst_acc_en", mac_acc_en, 0);
    check("midrst_in_a", mac_in_a, 0);
    check("midrst_res_data", res_data, 0);
    check("midrst_res_valid", res_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);
    send_cmd(1);
    send_op(8'd7, 8'd7);
    push_exp();
    wait_res();
    check("lat_post_rst", cyc - cmd_edge, 4);
    check_res("post_rst", res_data, res_ovf);
    tick();

    // TURN_CYC=3 instance: N=1 (7,7)
    b_res_ready = 1'b1;
    d0 = b_drv_cyc;
    check("t3_cmd_ready", b_cmd_ready, 1);
    b_cmd_valid = 1'b1;
    b_cmd_len   = LEN_W'(1);
    tick();
    cmd_edge    = cyc;
    b_cmd_valid = 1'b0;
    b_op_valid  = 1'b1;
    b_op_a      = 8'd7;
    b_op_b      = 8'd7;
    guard = 0;
    while (!b_op_ready && guard < 50) begin tick(); guard++; end
    check("t3_op_ready_wait", b_op_ready, 1);
    tick();
    b_op_valid = 1'b0;
    exp_sum = 49;
    push_exp();
    guard = 0;
    while (!b_res_valid && guard < 100) begin tick(); guard++; end
    check("t3_res_valid_wait", b_res_valid, 1);
    check("t3_latency", cyc - cmd_edge, 6);
    check("t3_drive_cyc", b_drv_cyc - d0, 3);
    check_res("t3", b_res_data, b_res_ovf);
    tick();
    check("t3_res_valid_pulse", b_res_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_host_seq.md
Name: mac_host_seq

Overview:
- Host-side sequencer for the 8x8 MAC core: the initiator end of its operand, accumulate and result-readback interface.
- Accepts a dot-product command of N operand pairs and clears the MAC accumulator.
- Streams the pairs into the MAC with one acc_en pulse each.
- Reads the 16-bit result back over the split bus (out_low plus the tri-stated high byte) under io_drive control, and returns it with a shadow-tracked overflow flag.

Parameters:
LEN_W, 8, width of command length (max 2^LEN_W-1 pairs)
TURN_CYC, 1, cycles io_drive is held before sampling the high byte (bus turnaround/settle), legal range 1..15

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when high with cmd_valid
cmd_len  input  LEN_W  number of operand pairs N, 0 legal
op_valid  input  1  operand pair offered
op_ready  output  1  operand pair accepted when high with op_valid
op_a  input  8  multiplicand
op_b  input  8  multiplier
res_valid  output  1  result available
res_ready  input  1  result consumed when high with res_valid
res_data  output  16  accumulated result, mod 2^16
res_ovf  output  1  true sum exceeded 16 bits
busy  output  1  high in any state other than IDLE
mac_rst_n  output  1  registered active-low clear to the MAC core
mac_acc_en  output  1  registered accumulate enable to the MAC core
mac_in_a  output  8  registered operand A to the MAC core
mac_in_b  output  8  registered operand B to the MAC core
mac_out_low  input  8  MAC accumulator low byte
mac_io_drive  output  1  registered enable; MAC drives the high byte onto the bus
mac_io_high_in  input  8  high-byte bus as seen by this block; sample-only, never driven

Behaviour:
- Reset values:
  - FSM=IDLE; mac_rst_n=0, which holds the MAC cleared while this block is in reset.
  - mac_acc_en=0, mac_in_a=0, mac_in_b=0, mac_io_drive=0.
  - res_valid=0, res_data=0, res_ovf=0, op_ready=0, busy=0.
  - cmd_ready=1 after reset release.
  - Shadow sum and pair counter = 0.
- Handshakes: a transfer occurs on a rising edge where valid and ready are both high. Every MAC-facing output is a flop.
- FSM states: IDLE, CLEAR, FEED, DRAIN, TURN, SAMPLE, RESP.
- IDLE:
  - cmd_ready=1, op_ready=0.
  - On cmd handshake: latch N, zero the counter and shadow sum, drive mac_rst_n=0, go to CLEAR.
- CLEAR (1 cycle):
  - mac_rst_n returns to 1 at the exit edge.
  - N=0: go to TURN. N>0: go to FEED.
- FEED:
  - op_ready=1 while counter<N.
  - On each op handshake: load mac_in_a/mac_in_b with op_a/op_b, set mac_acc_en=1 for exactly one cycle, add op_a*op_b to the 16+LEN_W-bit shadow sum, increment the counter.
  - Cycles without a handshake set mac_acc_en=0, and mac_in_a/b hold their values.
  - Back-to-back pairs are accepted every cycle.
  - The handshake that brings the counter to N moves to DRAIN.
- DRAIN (1 cycle): the MAC performs the final accumulate; mac_acc_en returns to 0 at exit; go to TURN.
- TURN:
  - mac_io_drive=1 for exactly TURN_CYC cycles.
  - At the final edge: capture res_data={mac_io_high_in, mac_out_low}, set res_ovf=(shadow_sum[15+LEN_W:16]!=0), deassert mac_io_drive, set res_valid=1, go to RESP.
  - SAMPLE is folded into this edge; the state encoding keeps SAMPLE for debug.
- RESP:
  - res_valid=1; res_data and res_ovf held stable until the res handshake.
  - On the handshake: res_valid=0, go to IDLE.
  - res_data and res_ovf keep their last value until the next capture.
- Latency (no op stalls, from the cmd handshake edge):
  - N>=1: res_valid rises at edge N+2+TURN_CYC.
  - N=0: res_valid rises at edge 1+TURN_CYC.
- Boundary rules:
  - cmd_valid outside IDLE: ignored; cmd_ready=0 there.
  - op_valid outside FEED: not accepted.
  - res_ready already high when res_valid rises: handshake on the first valid cycle; res_valid is a 1-cycle pulse.
  - The next command can be accepted at the earliest 1 cycle after the res handshake.
  - Arithmetic: the MAC result wraps mod 2^16. The shadow sum never wraps for N<=2^LEN_W-1.
  - mac_io_drive is never high outside TURN, so there is no bus contention in any other state.
  - rst asserted mid-operation: immediately forces the reset values, mac_rst_n=0 (MAC cleared), and aborts the in-flight command with no result.

Test Plan:
- Reset, then cmd N=1, pair (3,5), res_ready=1 -> res_data=15, res_ovf=0, res_valid at edge 4 after cmd (TURN_CYC=1), mac_io_drive high exactly 1 cycle.
- Cmd N=2, pairs (255,255),(255,255) -> res_data=0xFC02 (130050 mod 65536), res_ovf=1.
- Cmd N=0 -> res_data=0, res_ovf=0, res_valid at edge 2, mac_acc_en never asserted.
- Cmd N=3, pairs (1,2),(3,4),(5,6) with 1 idle op_valid cycle between pairs, res_ready low 5 cycles -> res_data=44 held stable, acc_en pulses=3, single handshake.
- Back-to-back: cmd N=1 (10,10) -> 100; then cmd N=1 (2,3) -> 6 (not 106), confirming the CLEAR pulse.
- rst pulse after 2 of 4 pairs -> all outputs at reset values with mac_rst_n=0 during rst; then cmd N=1 (7,7) -> 49; TURN_CYC=3 build -> mac_io_drive high 3 cycles, latency 6.
